// File: rtl/serial_alu_ctrl_pkg.sv
// rtl/serial_alu_ctrl_pkg.sv - shared state encoding and default sizing for serial_alu_ctrl
package serial_alu_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fa.sv
// rtl/fa.sv - single-bit full-adder cell
module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_alu_ctrl.sv
// rtl/serial_alu_ctrl.sv - bit-serial add/subtract controller; SERIAL_ALU_COMPARE_EN adds isNotEqual/isLessThan
module serial_alu_ctrl
  import serial_alu_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_result,
  output logic             carry_out,
  output logic             overflow,
  output logic             isNotEqual,
  output logic             isLessThan
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_out_q, carry_out_d;
  logic             overflow_q, overflow_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic             fa_s;
  logic             fa_co;
  logic             accept;
  logic             last_bit;

  // The one adder cell, fed from the LSBs of the shifting operands and the carry register.
  fa u_fa (
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  assign accept   = (state_q == IDLE) && in_valid && in_ready_q;
  assign last_bit = (state_q == RUN) && (cnt_q == CNT_W'(WIDTH - 1));

  // Sequencing: capture on accept, one bit per RUN cycle, hold result in DONE until taken.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    res_d       = res_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_sh_d  = data_operandA;
          b_sh_d  = data_operandB ^ {WIDTH{ctrl_sub}};
          carry_d = ctrl_sub;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
        res_d   = {fa_s, res_q[WIDTH-1:1]};
        carry_d = fa_co;
        if (last_bit) begin
          // carry_q here is the carry into the MSB; XOR with the carry out gives signed overflow.
          carry_out_d = fa_co;
          overflow_d  = carry_q ^ fa_co;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State and datapath registers; reset drops any operation in flight.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      res_q       <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      res_q       <= res_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign data_result = res_q;
  assign carry_out   = carry_out_q;
  assign overflow    = overflow_q;

`ifdef SERIAL_ALU_COMPARE_EN
  logic sub_q, sub_d;
  logic sticky_q, sticky_d;
  logic is_ne_q, is_ne_d;
  logic is_lt_q, is_lt_d;

  // Compare flags: sticky OR of difference bits, and sign-of-difference corrected by overflow.
  always_comb begin
    sub_d    = sub_q;
    sticky_d = sticky_q;
    is_ne_d  = is_ne_q;
    is_lt_d  = is_lt_q;
    if (accept) begin
      sub_d    = ctrl_sub;
      sticky_d = 1'b0;
    end else if (state_q == RUN) begin
      sticky_d = sticky_q | (sub_q & fa_s);
      if (last_bit) begin
        is_ne_d = sub_q & (sticky_q | fa_s);
        is_lt_d = sub_q & (fa_s ^ carry_q ^ fa_co);
      end
    end
  end

  // Compare flag registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sub_q    <= 1'b0;
      sticky_q <= 1'b0;
      is_ne_q  <= 1'b0;
      is_lt_q  <= 1'b0;
    end else begin
      sub_q    <= sub_d;
      sticky_q <= sticky_d;
      is_ne_q  <= is_ne_d;
      is_lt_q  <= is_lt_d;
    end
  end

  assign isNotEqual = is_ne_q;
  assign isLessThan = is_lt_q;
`else
  assign isNotEqual = 1'b0;
  assign isLessThan = 1'b0;
`endif

endmodule
